cv32e40p_apu_arbiter: RTL
=========================

CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of cores sharing one APU/FPU port (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the in-flight response-routing FIFO (power of 2, 2..16).
REQ-003 SHALL have the port clk_i  in  1  clock; this is the design's only clock.
REQ-004 SHALL have the port rst_ni  in  1  reset; reset is synchronous and active-low.
REQ-005 SHALL have the port core_req_i  in  NUM_CORES  per-core APU request.
REQ-006 SHALL have the port core_gnt_o  out  NUM_CORES  per-core grant, one-hot or zero.
REQ-007 SHALL have the port core_operands_i  in  NUM_CORES x APU_NARGS_CPU x 32  per-core operands.
REQ-008 SHALL have the port core_op_i  in  NUM_CORES x APU_WOP_CPU  per-core opcode.
REQ-009 SHALL have the port core_type_i  in  NUM_CORES x 3  per-core APU type.
REQ-010 SHALL have the port core_flags_i  in  NUM_CORES x APU_NDSFLAGS_CPU  per-core downstream flags.
REQ-011 SHALL have the port core_rvalid_o  out  NUM_CORES  per-core response valid, one-hot or zero.
REQ-012 SHALL have the port core_result_o  out  32  result, broadcast to all cores.
REQ-013 SHALL have the port core_flags_o  out  APU_NUSFLAGS_CPU  upstream flags, broadcast to all cores.
REQ-014 SHALL have the port apu_req_o  out  1  request to the shared APU.
REQ-015 SHALL have the port apu_gnt_i  in  1  grant from the shared APU.
REQ-016 SHALL have the ports apu_operands_o / apu_op_o / apu_type_o / apu_flags_o  out  widths as in REQ-007..010 for one core  request payload of the selected core.
REQ-017 SHALL have the port apu_rvalid_i  in  1  response valid from the APU.
REQ-018 SHALL have the ports apu_result_i  in  32  and apu_flags_i  in  APU_NUSFLAGS_CPU  response data.
REQ-019 SHALL have the port busy_o  out  1  asserted while the FIFO is non-empty.
REQ-020 SHALL have the port err_o  out  1  sticky flag for a response that arrives with no matching request.

Function
REQ-021 SHALL select, each cycle, the first requesting core at or after rr_ptr (modulo NUM_CORES), combinationally; no added request latency.
REQ-022 SHALL drive apu_req_o = (any core_req_i) AND NOT fifo_full, with the payload muxed from the selected core.
REQ-023 SHALL assert core_gnt_o[sel] = apu_req_o AND apu_gnt_i; every other grant bit is 0.
REQ-024 SHALL, on each accepted handshake, push sel into the FIFO and load rr_ptr = (sel+1) mod NUM_CORES.
REQ-025 SHALL leave rr_ptr unchanged when no handshake occurs; a stalled selection stays stable while its request stays high.
REQ-026 SHALL, on apu_rvalid_i with the FIFO non-empty, pop the head and assert core_rvalid_o[head] in the same cycle.
REQ-027 SHALL pass apu_result_i/apu_flags_i through combinationally to core_result_o/core_flags_o.
REQ-028 SHALL, when full, keep apu_req_o low even if a pop occurs in the same cycle; issue resumes the next cycle.
REQ-029 SHALL allow a push and a pop in the same cycle when not full; occupancy is then unchanged.
REQ-030 SHALL, on apu_rvalid_i with the FIFO empty, drive no core_rvalid_o, set err_o, and leave the FIFO unchanged.
REQ-031 SHALL return responses in issue order; the APU is required to answer in order.

Reset
REQ-032 SHALL, with rst_ni low at a rising edge of clk_i, set rr_ptr=0, empty the FIFO (read/write pointers 0) and clear err_o.
REQ-033 SHALL, while in reset, drive apu_req_o, core_gnt_o and core_rvalid_o to 0 regardless of inputs.
REQ-034 SHALL, on reset mid-operation, discard in-flight IDs; responses arriving after reset set err_o.

Structure
REQ-035 SHALL take APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU and APU_NUSFLAGS_CPU from cv32e40p_apu_core_pkg; no new package.
REQ-036 SHALL implement the ID FIFO as sub-module cv32e40p_apu_id_fifo (width $clog2(NUM_CORES), depth MAX_OUTSTANDING, full/empty outputs).

Verification
REQ-037 SHALL cover: all 4 cores request continuously with apu_gnt_i=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-038 SHALL cover: core 2 requests and apu_gnt_i is held 0 for 3 cycles -> apu_req_o high and payload stable for core 2, core_gnt_o=0100 on the 4th cycle.
REQ-039 SHALL cover: 4 grants with no rvalid -> apu_req_o=0 on the 5th cycle; rvalid then routes to the first issuer; issue resumes the next cycle.
REQ-040 SHALL cover: issue from cores 1,3,0, then 3 rvalids with results 0xA,0xB,0xC -> core_rvalid_o=0010,1000,0001 with matching core_result_o.
REQ-041 SHALL cover: apu_rvalid_i pulse with the FIFO empty -> core_rvalid_o=0 and err_o=1 until reset.
REQ-042 SHALL cover: rst_ni low for 1 cycle with 2 IDs in flight -> busy_o=0 and rr_ptr=0; the next request from core 3 is granted.

Source files
------------

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared by the core and the APU/FPU sharing logic.
package cv32e40p_apu_core_pkg;

    parameter int APU_NARGS_CPU    = 3;
    parameter int APU_WOP_CPU      = 6;
    parameter int APU_NDSFLAGS_CPU = 15;
    parameter int APU_NUSFLAGS_CPU = 5;

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-flight core-ID FIFO; records which core issued each accepted APU request.
module cv32e40p_apu_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PtrW:0]    r_wptr;
    logic [PtrW:0]    r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i && !full_o) begin
                r_wptr <= r_wptr + (PtrW + 1)'(1);
            end
            if (pop_i && !empty_o) begin
                r_rptr <= r_rptr + (PtrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            r_mem[r_wptr[PtrW-1:0]] <= data_i;
        end
    end

    assign data_o  = r_mem[r_rptr[PtrW-1:0]];
    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                     (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU/FPU port among several cores, with
// in-order response routing back to the issuing core.
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int unsigned NUM_CORES       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NUM_CORES-1:0]                      core_req_i,
    output logic [NUM_CORES-1:0]                      core_gnt_o,
    input  logic [NUM_CORES*APU_NARGS_CPU*32-1:0]     core_operands_i,
    input  logic [NUM_CORES*APU_WOP_CPU-1:0]          core_op_i,
    input  logic [NUM_CORES*3-1:0]                    core_type_i,
    input  logic [NUM_CORES*APU_NDSFLAGS_CPU-1:0]     core_flags_i,
    output logic [NUM_CORES-1:0]                      core_rvalid_o,
    output logic [31:0]                               core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]               core_flags_o,
    output logic                                      apu_req_o,
    input  logic                                      apu_gnt_i,
    output logic [APU_NARGS_CPU*32-1:0]               apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                    apu_op_o,
    output logic [2:0]                                apu_type_o,
    output logic [APU_NDSFLAGS_CPU-1:0]               apu_flags_o,
    input  logic                                      apu_rvalid_i,
    input  logic [31:0]                               apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]               apu_flags_i,
    output logic                                      busy_o,
    output logic                                      err_o
);

    localparam int unsigned IdxW = $clog2(NUM_CORES);
    localparam int unsigned OpsW = APU_NARGS_CPU * 32;

    logic [IdxW-1:0] r_rr_ptr;
    logic            r_err;
    logic [IdxW-1:0] w_sel;
    logic [IdxW-1:0] w_cand;
    logic            w_found;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [IdxW-1:0] w_head;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        w_sel   = r_rr_ptr;
        w_cand  = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            w_cand = IdxW'((32'(r_rr_ptr) + i) % NUM_CORES);
            if (!w_found && core_req_i[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        apu_operands_o = '0;
        apu_op_o       = '0;
        apu_type_o     = '0;
        apu_flags_o    = '0;
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            if (IdxW'(c) == w_sel) begin
                apu_operands_o = core_operands_i[c*OpsW +: OpsW];
                apu_op_o       = core_op_i[c*APU_WOP_CPU +: APU_WOP_CPU];
                apu_type_o     = core_type_i[c*3 +: 3];
                apu_flags_o    = core_flags_i[c*APU_NDSFLAGS_CPU +: APU_NDSFLAGS_CPU];
            end
        end
    end

    // A pop in the same cycle cannot free a slot for issue while full.
    assign apu_req_o = rst_ni & (|core_req_i) & ~w_full;
    assign w_push    = apu_req_o & apu_gnt_i;
    assign w_pop     = rst_ni & apu_rvalid_i & ~w_empty;

    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        if (w_push) begin
            core_gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            core_rvalid_o[w_head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= (w_sel == IdxW'(NUM_CORES - 1)) ? '0 : w_sel + IdxW'(1);
            end
            if (apu_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    cv32e40p_apu_id_fifo #(
        .WIDTH (IdxW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign core_result_o = apu_result_i;
    assign core_flags_o  = apu_flags_i;
    assign busy_o        = ~w_empty;
    assign err_o         = r_err;

endmodule
